latch_write_sched: RTL and testbench



---
 rtl/latch_sched_defs.sv | 22 ++
 rtl/rr_arb2.sv | 17 +
 rtl/latch_write_sched.sv | 144 ++++++++++++++
 tb/tb_latch_write_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_sched_defs.sv
// Shared definitions for the latch write scheduler: FSM encoding and the
// phase-counter width helper.
package latch_sched_defs;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      OPEN  = 3'd2,
      HOLD  = 3'd3,
      ACK   = 3'd4
   } state_t;

   // Wide enough to hold the largest phase length minus one, plus a spare bit.
   function automatic int cnt_width(input int setup_cyc, input int open_cyc, input int hold_cyc);
      int m;
      m = setup_cyc;
      if (open_cyc > m) m = open_cyc;
      if (hold_cyc > m) m = hold_cyc;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins; on a tie the requester that
// was not granted last time wins.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt_valid,
   output logic gnt_idx
);

   always_comb begin
      gnt_valid = req0 | req1;
      if (req0 && req1) gnt_idx = ~last;
      else              gnt_idx = req1;
   end

endmodule

// File: rtl/latch_write_sched.sv
// Shares one external transparent-latch bank between two 4-phase writers,
// framing each write as setup / open / hold phases so lat_d is stable around lat_c.
module latch_write_sched
   import latch_sched_defs::*;
#(
   parameter int W         = 8,
   parameter int SETUP_CYC = 1,
   parameter int OPEN_CYC  = 1,
   parameter int HOLD_CYC  = 1
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         req0,
   input  logic [W-1:0] d0,
   output logic         ack0,
   input  logic         req1,
   input  logic [W-1:0] d1,
   output logic         ack1,
   output logic [W-1:0] lat_d,
   output logic         lat_c,
   output logic         busy,
   output logic         owner
);

   localparam int CW = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

   state_t         r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic [W-1:0]   r_lat_d, w_lat_d_nxt;
   logic           r_lat_c, w_lat_c_nxt;
   logic           r_ack0, w_ack0_nxt;
   logic           r_ack1, w_ack1_nxt;
   logic           r_busy, w_busy_nxt;
   logic           r_owner, w_owner_nxt;
   logic           w_gnt_valid, w_gnt_idx, w_req_owner;

   rr_arb2 u_arb (
      .req0      (req0),
      .req1      (req1),
      .last      (r_owner),
      .gnt_valid (w_gnt_valid),
      .gnt_idx   (w_gnt_idx)
   );

   assign w_req_owner = r_owner ? req1 : req0;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lat_d_nxt = r_lat_d;
      w_lat_c_nxt = r_lat_c;
      w_ack0_nxt  = r_ack0;
      w_ack1_nxt  = r_ack1;
      w_busy_nxt  = r_busy;
      w_owner_nxt = r_owner;
      case (r_state)
         IDLE: begin
            if (w_gnt_valid) begin
               w_owner_nxt = w_gnt_idx;
               w_lat_d_nxt = w_gnt_idx ? d1 : d0;
               w_busy_nxt  = 1'b1;
               w_cnt_nxt   = SETUP_LD;
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (r_cnt == '0) begin
               w_cnt_nxt   = OPEN_LD;
               w_lat_c_nxt = 1'b1;
               w_state_nxt = OPEN;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         OPEN: begin
            if (r_cnt == '0) begin
               w_cnt_nxt   = HOLD_LD;
               w_lat_c_nxt = 1'b0;
               w_state_nxt = HOLD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         HOLD: begin
            if (r_cnt == '0) begin
               w_ack0_nxt  = ~r_owner;
               w_ack1_nxt  = r_owner;
               w_state_nxt = ACK;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ACK: begin
            // Release only once the owner's request is seen low (4-phase return).
            if (!w_req_owner) begin
               w_ack0_nxt  = 1'b0;
               w_ack1_nxt  = 1'b0;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_lat_c_nxt = 1'b0;
            w_ack0_nxt  = 1'b0;
            w_ack1_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_lat_d <= '0;
         r_lat_c <= 1'b0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_busy  <= 1'b0;
         r_owner <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lat_d <= w_lat_d_nxt;
         r_lat_c <= w_lat_c_nxt;
         r_ack0  <= w_ack0_nxt;
         r_ack1  <= w_ack1_nxt;
         r_busy  <= w_busy_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   assign lat_d = r_lat_d;
   assign lat_c = r_lat_c;
   assign ack0  = r_ack0;
   assign ack1  = r_ack1;
   assign busy  = r_busy;
   assign owner = r_owner;

endmodule

// File: tb/tb_latch_write_sched.sv
// Directed bench for latch_write_sched: default-timing instance plus a
// stretched-timing instance (2/3/2) for the data-stability scenario.
module tb_latch_write_sched;

   localparam int W = 8;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // default-timing instance
   logic         reset_, req0, req1;
   logic [W-1:0] d0, d1;
   logic         ack0, ack1, lat_c, busy, owner;
   logic [W-1:0] lat_d;

   // stretched-timing instance
   logic         reset_b, req0_b, req1_b;
   logic [W-1:0] d0_b, d1_b;
   logic         ack0_b, ack1_b, lat_c_b, busy_b, owner_b;
   logic [W-1:0] lat_d_b;

   logic [W-1:0] r_latch_q;

   latch_write_sched #(.W(W), .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1)) u_dut (
      .clock (clock), .reset_ (reset_),
      .req0  (req0),  .d0     (d0), .ack0 (ack0),
      .req1  (req1),  .d1     (d1), .ack1 (ack1),
      .lat_d (lat_d), .lat_c  (lat_c), .busy (busy), .owner (owner)
   );

   latch_write_sched #(.W(W), .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u_dut_b (
      .clock (clock),   .reset_ (reset_b),
      .req0  (req0_b),  .d0     (d0_b), .ack0 (ack0_b),
      .req1  (req1_b),  .d1     (d1_b), .ack1 (ack1_b),
      .lat_d (lat_d_b), .lat_c  (lat_c_b), .busy (busy_b), .owner (owner_b)
   );

   // Behavioural model of the external latch bank.
   always_latch begin
      if (lat_c) r_latch_q <= lat_d;
   end

   task automatic do_reset();
      reset_ = 1'b0;
      req0   = 1'b0;
      req1   = 1'b0;
      repeat (2) @(negedge clock);
      reset_ = 1'b1;
   endtask

   task automatic test_reset();
      reset_ = 1'b0;
      req0   = 1'b1;
      d0     = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if ({lat_c, lat_d, ack0, ack1, busy, owner} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state cyc%0d: got lat_c=%b lat_d=%h ack0=%b ack1=%b busy=%b owner=%b, want 0 00 0 0 0 1",
                     i, lat_c, lat_d, ack0, ack1, busy, owner);
         end
      end
      reset_ = 1'b1;
      @(negedge clock);
      checks++;
      if ({busy, owner, lat_d} !== {1'b1, 1'b0, 8'h5A}) begin
         errors++;
         $display("FAIL reset_release_grant: got busy=%b owner=%b lat_d=%h, want 1 0 5a", busy, owner, lat_d);
      end
      req0 = 1'b0;
   endtask

   task automatic test_single_write();
      do_reset();
      req0 = 1'b1;
      d0   = 8'hA5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         d0 = 8'h00;
         checks++;
         if (lat_d !== 8'hA5 || lat_c !== (i == 1) || ack0 !== (i == 3) || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL single_write cyc%0d: got lat_d=%h lat_c=%b ack0=%b ack1=%b, want a5 %b %b 0",
                     i, lat_d, lat_c, ack0, ack1, (i == 1), (i == 3));
         end
         if (i == 3) req0 = 1'b0;
      end
      checks++;
      if (busy !== 1'b0 || r_latch_q !== 8'hA5 || owner !== 1'b0) begin
         errors++;
         $display("FAIL single_write_end: got busy=%b latch=%h owner=%b, want 0 a5 0", busy, r_latch_q, owner);
      end
   endtask

   task automatic test_round_robin();
      logic [W-1:0] exp_d [2];
      bit found;
      int idx;
      exp_d[0] = 8'h11;
      exp_d[1] = 8'h22;
      do_reset();
      d0   = 8'h11;
      d1   = 8'h22;
      req0 = 1'b1;
      req1 = 1'b1;
      for (int n = 0; n < 4; n++) begin
         idx   = n % 2;
         found = 1'b0;
         for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clock);
            checks++;
            if (ack0 && ack1) begin
               errors++;
               $display("FAIL rr_both_acks: got ack0=1 ack1=1, want at most one");
            end
            if (ack0 || ack1) found = 1'b1;
         end
         checks++;
         if (!found) begin
            errors++;
            $display("FAIL rr_timeout grant%0d: got no ack within 20 cycles, want ack%0d", n, idx);
         end else if ({ack1, ack0} !== (idx == 0 ? 2'b01 : 2'b10) || lat_d !== exp_d[idx] || owner !== idx[0]) begin
            errors++;
            $display("FAIL rr_grant%0d: got ack1ack0=%b%b lat_d=%h owner=%b, want owner %0d lat_d %h",
                     n, ack1, ack0, lat_d, owner, idx, exp_d[idx]);
         end
         if (idx == 0) req0 = 1'b0;
         else          req1 = 1'b0;
         @(negedge clock);
         checks++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_release%0d: got ack0=%b ack1=%b busy=%b, want 0 0 0", n, ack0, ack1, busy);
         end
         if (idx == 0) req0 = 1'b1;
         else          req1 = 1'b1;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   task automatic test_data_stability();
      int lat_c_cycles;
      lat_c_cycles = 0;
      reset_b = 1'b0;
      req0_b  = 1'b0;
      req1_b  = 1'b0;
      repeat (2) @(negedge clock);
      reset_b = 1'b1;
      req0_b  = 1'b1;
      d0_b    = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         d0_b = 8'($urandom_range(0, 255));
         if (lat_c_b) lat_c_cycles++;
         checks++;
         if (lat_d_b !== 8'h3C || lat_c_b !== (i >= 2 && i <= 4) || ack0_b !== (i == 7) || ack1_b !== 1'b0) begin
            errors++;
            $display("FAIL stability cyc%0d: got lat_d=%h lat_c=%b ack0=%b ack1=%b, want 3c %b %b 0",
                     i, lat_d_b, lat_c_b, ack0_b, ack1_b, (i >= 2 && i <= 4), (i == 7));
         end
      end
      req0_b = 1'b0;
      @(negedge clock);
      checks++;
      if (lat_c_cycles != 3 || ack0_b !== 1'b0 || busy_b !== 1'b0 || lat_d_b !== 8'h3C) begin
         errors++;
         $display("FAIL stability_end: got lat_c_cycles=%0d ack0=%b busy=%b lat_d=%h, want 3 0 0 3c",
                  lat_c_cycles, ack0_b, busy_b, lat_d_b);
      end
   endtask

   task automatic test_early_drop();
      do_reset();
      req1 = 1'b1;
      d1   = 8'h77;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         req1 = 1'b0;
         checks++;
         if (ack1 !== (i == 3) || ack0 !== 1'b0 || lat_d !== 8'h77 || busy !== (i <= 3)) begin
            errors++;
            $display("FAIL early_drop cyc%0d: got ack1=%b ack0=%b lat_d=%h busy=%b, want %b 0 77 %b",
                     i, ack1, ack0, lat_d, busy, (i == 3), (i <= 3));
         end
      end
   endtask

   task automatic test_midop_reset();
      bit found;
      int lat;
      do_reset();
      req0 = 1'b1;
      d0   = 8'h99;
      repeat (2) @(negedge clock);
      checks++;
      if (lat_c !== 1'b1) begin
         errors++;
         $display("FAIL midop_open: got lat_c=%b, want 1", lat_c);
      end
      reset_ = 1'b0;
      req0   = 1'b0;
      @(negedge clock);
      checks++;
      if (lat_c !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0 || owner !== 1'b1) begin
         errors++;
         $display("FAIL midop_reset: got lat_c=%b busy=%b ack0=%b owner=%b, want 0 0 0 1", lat_c, busy, ack0, owner);
      end
      reset_ = 1'b1;
      req0   = 1'b1;
      d0     = 8'hC3;
      found  = 1'b0;
      lat    = 0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clock);
         if (ack0) found = 1'b1;
         else      lat++;
      end
      checks++;
      if (!found || lat != 3 || lat_d !== 8'hC3) begin
         errors++;
         $display("FAIL midop_rewrite: got found=%b wait=%0d lat_d=%h, want 1 3 c3", found, lat, lat_d);
      end
      req0 = 1'b0;
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b0 || busy !== 1'b0 || r_latch_q !== 8'hC3) begin
         errors++;
         $display("FAIL midop_end: got ack0=%b busy=%b latch=%h, want 0 0 c3", ack0, busy, r_latch_q);
      end
   endtask

   initial begin
      reset_  = 1'b0;
      req0    = 1'b0;
      req1    = 1'b0;
      d0      = '0;
      d1      = '0;
      reset_b = 1'b0;
      req0_b  = 1'b0;
      req1_b  = 1'b0;
      d0_b    = '0;
      d1_b    = '0;
      test_reset();
      test_single_write();
      test_round_robin();
      test_data_stability();
      test_early_drop();
      test_midop_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
